// File: rtl/psg_write_sequencer.sv
// psg_write_sequencer: two-requester round-robin write queue feeding the
// AY-3-8913/YM2149 bus protocol (latch address, gap, write data, gap) for the
// two-PSG Mockingboard datapath. Also owns the shared PSG reset line.
module psg_write_sequencer #(
  parameter int PHASE_TICKS = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                         clk_logic,
  input  logic                         system_reset_n,
  input  logic                         tick_i,
  input  logic                         a_req_i,
  input  logic                         a_chip_i,
  input  logic [3:0]                   a_reg_i,
  input  logic [7:0]                   a_data_i,
  output logic                         a_ack_o,
  input  logic                         b_req_i,
  input  logic                         b_chip_i,
  input  logic [3:0]                   b_reg_i,
  input  logic [7:0]                   b_data_i,
  output logic                         b_ack_o,
  input  logic                         reset_psg_i,
  output logic                         psg_sel_o,
  output logic                         psg_bdir_o,
  output logic                         psg_bc_o,
  output logic                         psg_reset_n_o,
  output logic [7:0]                   psg_data_o,
  output logic                         busy_o,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(2*PHASE_TICKS + 1);
  localparam logic [TW-1:0] PH_LOAD  = TW'(PHASE_TICKS - 1);
  localparam logic [TW-1:0] RST_LOAD = TW'(2*PHASE_TICKS - 1);

  typedef struct packed {
    logic       chip;
    logic [3:0] rg;
    logic [7:0] data;
  } wr_req_t;

  typedef enum logic [2:0] {
    S_RST, S_IDLE, S_LATCH, S_GAP1, S_WRITE, S_GAP2
  } state_t;

  // FIFO storage and pointers
  wr_req_t         r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [CW-1:0]   r_count;

  // arbiter state: registered acks double as the "acked last cycle" guard
  logic            r_a_ack, r_b_ack;
  logic            r_rr;       // 0 = A has priority on a collision

  // sequencer state
  state_t          r_state;
  logic [TW-1:0]   r_cnt;
  logic            r_pend;
  wr_req_t         r_hold;
  logic            r_sel, r_bdir, r_bc, r_reset_n;
  logic [7:0]      r_data;

  logic            w_full, w_empty;
  logic            w_a_elig, w_b_elig, w_win_a, w_win_b;
  logic            w_push, w_pop, w_rst_go;
  wr_req_t         w_push_d, w_head;

  assign w_full   = (r_count == CW'(FIFO_DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_a_elig = a_req_i && !w_full && !r_a_ack;
  assign w_b_elig = b_req_i && !w_full && !r_b_ack;
  assign w_win_a  = w_a_elig && (!w_b_elig || !r_rr);
  assign w_win_b  = w_b_elig && (!w_a_elig ||  r_rr);
  assign w_push   = w_win_a || w_win_b;
  assign w_push_d = w_win_a ? wr_req_t'{a_chip_i, a_reg_i, a_data_i}
                            : wr_req_t'{b_chip_i, b_reg_i, b_data_i};
  assign w_head   = r_mem[r_rptr];

  // pending PSG reset is only serviced from IDLE on a tick
  assign w_rst_go = (r_state == S_IDLE) && tick_i && r_pend;
  // the pop decision must match the IDLE branch of the FSM exactly
  assign w_pop    = (r_state == S_IDLE) && tick_i && !r_pend && !w_empty;

  // ack pulses and collision round-robin pointer
  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      r_a_ack <= 1'b0;
      r_b_ack <= 1'b0;
      r_rr    <= 1'b0;
    end else begin
      r_a_ack <= w_win_a;
      r_b_ack <= w_win_b;
      if (w_a_elig && w_b_elig) r_rr <= ~r_rr;
    end
  end

  // write-request FIFO; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_push_d;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // sticky reset request; a new request in the clearing cycle wins
  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) r_pend <= 1'b0;
    else                 r_pend <= reset_psg_i || (r_pend && !w_rst_go);
  end

  // bus-phase FSM, advances only on tick_i; outputs registered on transition
  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      r_state   <= S_RST;
      r_cnt     <= RST_LOAD;
      r_hold    <= '0;
      r_sel     <= 1'b0;
      r_bdir    <= 1'b0;
      r_bc      <= 1'b0;
      r_reset_n <= 1'b0;
      r_data    <= '0;
    end else if (tick_i) begin
      case (r_state)
        S_RST: begin
          if (r_cnt == '0) begin
            r_state   <= S_IDLE;
            r_reset_n <= 1'b1;
          end else r_cnt <= r_cnt - 1'b1;
        end
        S_IDLE: begin
          if (r_pend) begin
            r_state   <= S_RST;
            r_cnt     <= RST_LOAD;
            r_reset_n <= 1'b0;
          end else if (!w_empty) begin
            r_hold  <= w_head;
            r_state <= S_LATCH;
            r_cnt   <= PH_LOAD;
            r_bdir  <= 1'b1;
            r_bc    <= 1'b1;
            r_data  <= {4'b0, w_head.rg};
            r_sel   <= w_head.chip;
          end
        end
        S_LATCH: begin
          if (r_cnt == '0) begin
            r_state <= S_GAP1;
            r_cnt   <= PH_LOAD;
            r_bdir  <= 1'b0;
            r_bc    <= 1'b0;
          end else r_cnt <= r_cnt - 1'b1;
        end
        S_GAP1: begin
          if (r_cnt == '0) begin
            r_state <= S_WRITE;
            r_cnt   <= PH_LOAD;
            r_bdir  <= 1'b1;
            r_bc    <= 1'b0;
            r_data  <= r_hold.data;
          end else r_cnt <= r_cnt - 1'b1;
        end
        S_WRITE: begin
          if (r_cnt == '0) begin
            r_state <= S_GAP2;
            r_cnt   <= PH_LOAD;
            r_bdir  <= 1'b0;
            r_bc    <= 1'b0;
          end else r_cnt <= r_cnt - 1'b1;
        end
        S_GAP2: begin
          if (r_cnt == '0) r_state <= S_IDLE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        default: begin
          r_state   <= S_RST;
          r_cnt     <= RST_LOAD;
          r_reset_n <= 1'b0;
          r_bdir    <= 1'b0;
          r_bc      <= 1'b0;
        end
      endcase
    end
  end

  assign a_ack_o       = r_a_ack;
  assign b_ack_o       = r_b_ack;
  assign psg_sel_o     = r_sel;
  assign psg_bdir_o    = r_bdir;
  assign psg_bc_o      = r_bc;
  assign psg_reset_n_o = r_reset_n;
  assign psg_data_o    = r_data;
  assign busy_o        = (r_state != S_IDLE) || !w_empty;
  assign fifo_count_o  = r_count;

endmodule

// File: tb/tb_psg_write_sequencer.sv
// Bench for psg_write_sequencer: scenario tasks plus a bus monitor that turns
// observed PSG bus phases back into (chip, latch byte, value) writes.
module tb_psg_write_sequencer;
  localparam int PT = 1;
  localparam int FD = 4;
  localparam int NR = 8;

  logic clk_logic = 1'b0, system_reset_n = 1'b0, tick_i = 1'b0;
  logic a_req_i = 1'b0, a_chip_i = 1'b0, b_req_i = 1'b0, b_chip_i = 1'b0;
  logic [3:0] a_reg_i = '0, b_reg_i = '0;
  logic [7:0] a_data_i = '0, b_data_i = '0;
  logic a_ack_o, b_ack_o, reset_psg_i = 1'b0;
  logic psg_sel_o, psg_bdir_o, psg_bc_o, psg_reset_n_o, busy_o;
  logic [7:0] psg_data_o;
  logic [$clog2(FD):0] fifo_count_o;

  int n_checks = 0, n_pass = 0;
  logic [16:0] obs[$];      // {sel, latch byte, write byte}
  logic [8:0]  cap;
  logic [1:0]  prev_bus = 2'b00;
  bit done_a, done_b;

  always #5 clk_logic = ~clk_logic;

  psg_write_sequencer #(.PHASE_TICKS(PT), .FIFO_DEPTH(FD)) dut (
    .clk_logic(clk_logic), .system_reset_n(system_reset_n), .tick_i(tick_i),
    .a_req_i(a_req_i), .a_chip_i(a_chip_i), .a_reg_i(a_reg_i), .a_data_i(a_data_i), .a_ack_o(a_ack_o),
    .b_req_i(b_req_i), .b_chip_i(b_chip_i), .b_reg_i(b_reg_i), .b_data_i(b_data_i), .b_ack_o(b_ack_o),
    .reset_psg_i(reset_psg_i), .psg_sel_o(psg_sel_o), .psg_bdir_o(psg_bdir_o), .psg_bc_o(psg_bc_o),
    .psg_reset_n_o(psg_reset_n_o), .psg_data_o(psg_data_o), .busy_o(busy_o), .fifo_count_o(fifo_count_o));

  // bus monitor: address latched on entry to (1,1), write recorded on entry to (1,0)
  always @(negedge clk_logic) begin
    if (!system_reset_n) prev_bus = 2'b00;
    else begin
      if ({psg_bdir_o, psg_bc_o} == 2'b11 && prev_bus != 2'b11) cap = {psg_sel_o, psg_data_o};
      if ({psg_bdir_o, psg_bc_o} == 2'b10 && prev_bus != 2'b10) obs.push_back({cap, psg_data_o});
      prev_bus = {psg_bdir_o, psg_bc_o};
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_logic); #1;
  endtask

  task automatic cyc(input logic tk);
    tick_i = tk; step();
  endtask

  // hold a request until its ack is seen (or maxc cycles pass)
  task automatic send(input bit who, input logic c, input logic [3:0] r, input logic [7:0] d,
                      input int maxc, output bit ok);
    ok = 1'b0;
    if (!who) begin a_chip_i = c; a_reg_i = r; a_data_i = d; a_req_i = 1'b1; end
    else      begin b_chip_i = c; b_reg_i = r; b_data_i = d; b_req_i = 1'b1; end
    for (int i = 0; i < maxc && !ok; i++) begin
      step();
      if ((!who && a_ack_o) || (who && b_ack_o)) ok = 1'b1;
    end
    if (!who) a_req_i = 1'b0; else b_req_i = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int k;
    tick_i = 1'b1;
    for (k = 0; k < maxc && busy_o !== 1'b0; k++) step();
    n_checks++; if (busy_o !== 1'b0) $display("FAIL drain_timeout: busy=%b after %0d cycles, exp 0", busy_o, k); else n_pass++;
  endtask

  task automatic test_reset();
    int ticks = 0, bad = 0;
    system_reset_n = 1'b0; tick_i = 1'b0;
    #22;
    n_checks++; if ({psg_bdir_o, psg_bc_o, psg_sel_o} !== 3'b000) $display("FAIL rst_bus: got %b exp 000", {psg_bdir_o, psg_bc_o, psg_sel_o}); else n_pass++;
    n_checks++; if (psg_data_o !== 8'h00) $display("FAIL rst_data: got %h exp 00", psg_data_o); else n_pass++;
    n_checks++; if (psg_reset_n_o !== 1'b0) $display("FAIL rst_psgrst: got %b exp 0", psg_reset_n_o); else n_pass++;
    n_checks++; if ({a_ack_o, b_ack_o} !== 2'b00) $display("FAIL rst_acks: got %b exp 00", {a_ack_o, b_ack_o}); else n_pass++;
    n_checks++; if (fifo_count_o !== 0) $display("FAIL rst_count: got %0d exp 0", fifo_count_o); else n_pass++;
    @(negedge clk_logic); system_reset_n = 1'b1;
    step();
    for (int k = 0; k < 40 && psg_reset_n_o !== 1'b1; k++) begin
      cyc(k % 4 == 3);
      if (tick_i) ticks++;
      if (psg_bdir_o || psg_bc_o) bad++;
    end
    n_checks++; if (ticks != 2*PT) $display("FAIL rst_ticks: got %0d ticks exp %0d", ticks, 2*PT); else n_pass++;
    n_checks++; if (psg_reset_n_o !== 1'b1) $display("FAIL rst_release: got %b exp 1", psg_reset_n_o); else n_pass++;
    n_checks++; if (bad != 0) $display("FAIL rst_bus_quiet: got %0d active cycles exp 0", bad); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL rst_busy: got %b exp 0", busy_o); else n_pass++;
  endtask

  task automatic test_single();
    bit ok;
    obs.delete(); tick_i = 1'b1;
    send(0, 1'b0, 4'd7, 8'h38, 5, ok);
    n_checks++; if (!ok) $display("FAIL single_ack: got %b exp 1", ok); else n_pass++;
    n_checks++; if (fifo_count_o !== 1) $display("FAIL single_count: got %0d exp 1", fifo_count_o); else n_pass++;
    cyc(1);
    n_checks++; if (a_ack_o !== 1'b0) $display("FAIL single_ack_pulse: got %b exp 0", a_ack_o); else n_pass++;
    n_checks++; if ({psg_bdir_o, psg_bc_o, psg_sel_o, psg_data_o} !== {3'b110, 8'h07}) $display("FAIL single_latch: got %b %h exp 110 07", {psg_bdir_o, psg_bc_o, psg_sel_o}, psg_data_o); else n_pass++;
    cyc(1);
    n_checks++; if ({psg_bdir_o, psg_bc_o, psg_data_o} !== {2'b00, 8'h07}) $display("FAIL single_gap1: got %b %h exp 00 07", {psg_bdir_o, psg_bc_o}, psg_data_o); else n_pass++;
    cyc(1);
    n_checks++; if ({psg_bdir_o, psg_bc_o, psg_data_o} !== {2'b10, 8'h38}) $display("FAIL single_write: got %b %h exp 10 38", {psg_bdir_o, psg_bc_o}, psg_data_o); else n_pass++;
    cyc(1);
    n_checks++; if ({psg_bdir_o, psg_bc_o, busy_o} !== 3'b001) $display("FAIL single_gap2: got %b exp 001", {psg_bdir_o, psg_bc_o, busy_o}); else n_pass++;
    cyc(1);
    n_checks++; if (busy_o !== 1'b0) $display("FAIL single_idle: busy got %b exp 0", busy_o); else n_pass++;
    n_checks++; if (obs.size() != 1 || obs[0] !== {1'b0, 8'h07, 8'h38}) $display("FAIL single_trace: got %0d entries first %h exp 1 entry 00738", obs.size(), obs.size() ? obs[0] : 17'h0); else n_pass++;
  endtask

  task automatic test_collision();
    logic [16:0] exp_q[$];
    obs.delete(); tick_i = 1'b0;
    a_chip_i = 0; a_reg_i = 4'h1; a_data_i = 8'h11; b_chip_i = 1; b_reg_i = 4'h2; b_data_i = 8'h22;
    a_req_i = 1; b_req_i = 1; step();
    n_checks++; if ({a_ack_o, b_ack_o} !== 2'b10) $display("FAIL coll1_first: got %b exp 10", {a_ack_o, b_ack_o}); else n_pass++;
    a_req_i = 0; step();
    n_checks++; if ({a_ack_o, b_ack_o} !== 2'b01) $display("FAIL coll1_second: got %b exp 01", {a_ack_o, b_ack_o}); else n_pass++;
    b_req_i = 0; step();
    a_reg_i = 4'h3; a_data_i = 8'h33; b_reg_i = 4'h4; b_data_i = 8'h44;
    a_req_i = 1; b_req_i = 1; step();
    n_checks++; if ({a_ack_o, b_ack_o} !== 2'b01) $display("FAIL coll2_first: got %b exp 01", {a_ack_o, b_ack_o}); else n_pass++;
    b_req_i = 0; step();
    n_checks++; if ({a_ack_o, b_ack_o} !== 2'b10) $display("FAIL coll2_second: got %b exp 10", {a_ack_o, b_ack_o}); else n_pass++;
    a_req_i = 0; step();
    n_checks++; if (fifo_count_o !== 4) $display("FAIL coll_count: got %0d exp 4", fifo_count_o); else n_pass++;
    exp_q = '{{1'b0, 8'h01, 8'h11}, {1'b1, 8'h02, 8'h22}, {1'b1, 8'h04, 8'h44}, {1'b0, 8'h03, 8'h33}};
    drain(100);
    n_checks++; if (obs.size() != 4) $display("FAIL coll_trace_len: got %0d exp 4", obs.size()); else n_pass++;
    for (int i = 0; i < 4 && i < obs.size(); i++) begin
      n_checks++; if (obs[i] !== exp_q[i]) $display("FAIL coll_trace[%0d]: got %h exp %h", i, obs[i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_full();
    bit ok; int acks = 0;
    obs.delete(); tick_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(0, 1'(i), 4'(i), 8'(8'h50 + i), 6, ok);
      if (ok) acks++;
    end
    n_checks++; if (acks != 4) $display("FAIL full_acks: got %0d exp 4", acks); else n_pass++;
    n_checks++; if (fifo_count_o !== FD) $display("FAIL full_count: got %0d exp %0d", fifo_count_o, FD); else n_pass++;
    a_chip_i = 0; a_reg_i = 4'd4; a_data_i = 8'h54; a_req_i = 1'b1; acks = 0;
    for (int i = 0; i < 5; i++) begin step(); if (a_ack_o) acks++; end
    n_checks++; if (acks != 0) $display("FAIL full_stall: got %0d acks exp 0", acks); else n_pass++;
    cyc(1);
    n_checks++; if ({a_ack_o, fifo_count_o} !== {1'b0, 3'd3}) $display("FAIL full_pop: ack/count got %b/%0d exp 0/3", a_ack_o, fifo_count_o); else n_pass++;
    cyc(0);
    n_checks++; if ({a_ack_o, fifo_count_o} !== {1'b1, 3'd4}) $display("FAIL full_fifth: ack/count got %b/%0d exp 1/4", a_ack_o, fifo_count_o); else n_pass++;
    a_req_i = 1'b0;
    tick_i = 1'b1;
    send(0, 1'b1, 4'd5, 8'h55, 100, ok);
    n_checks++; if (!ok) $display("FAIL full_sixth: got %b exp 1", ok); else n_pass++;
    drain(200);
    n_checks++; if (obs.size() != 6) $display("FAIL full_trace_len: got %0d exp 6", obs.size()); else n_pass++;
    for (int i = 0; i < 6 && i < obs.size(); i++) begin
      n_checks++; if (obs[i] !== {1'(i), 4'h0, 4'(i), 8'(8'h50 + i)}) $display("FAIL full_trace[%0d]: got %h exp %h", i, obs[i], {1'(i), 4'h0, 4'(i), 8'(8'h50 + i)}); else n_pass++;
    end
  endtask

  task automatic test_psg_reset();
    bit ok; int k, lows = 0, obs_at_low = -1, cnt_at_low = -1;
    logic [16:0] exp_q[$];
    obs.delete(); tick_i = 1'b0;
    send(0, 1'b1, 4'd8, 8'h0F, 6, ok);
    send(1, 1'b0, 4'd14, 8'hAA, 6, ok);
    send(0, 1'b1, 4'd15, 8'h55, 6, ok);
    tick_i = 1'b1;
    for (k = 0; k < 50 && !(psg_bdir_o === 1'b1 && psg_bc_o === 1'b0); k++) step();
    n_checks++; if ({psg_bdir_o, psg_bc_o, psg_data_o} !== {2'b10, 8'h0F}) $display("FAIL prst_write_seen: got %b %h exp 10 0f", {psg_bdir_o, psg_bc_o}, psg_data_o); else n_pass++;
    reset_psg_i = 1'b1; step(); reset_psg_i = 1'b0;
    for (k = 0; k < 80 && busy_o !== 1'b0; k++) begin
      step();
      if (psg_reset_n_o === 1'b0) begin
        if (obs_at_low < 0) begin obs_at_low = obs.size(); cnt_at_low = fifo_count_o; end
        lows++;
      end
    end
    n_checks++; if (obs_at_low != 1) $display("FAIL prst_write_first: writes before reset got %0d exp 1", obs_at_low); else n_pass++;
    n_checks++; if (cnt_at_low != 2) $display("FAIL prst_fifo_kept: got %0d exp 2", cnt_at_low); else n_pass++;
    n_checks++; if (lows != 2*PT) $display("FAIL prst_len: reset low cycles got %0d exp %0d", lows, 2*PT); else n_pass++;
    exp_q = '{{1'b1, 8'h08, 8'h0F}, {1'b0, 8'h0E, 8'hAA}, {1'b1, 8'h0F, 8'h55}};
    n_checks++; if (obs.size() != 3) $display("FAIL prst_trace_len: got %0d exp 3", obs.size()); else n_pass++;
    for (int i = 0; i < 3 && i < obs.size(); i++) begin
      n_checks++; if (obs[i] !== exp_q[i]) $display("FAIL prst_trace[%0d]: got %h exp %h", i, obs[i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [16:0] la[$], lb[$];
    int ia = 0, ib = 0, acks_a = 0, acks_b = 0;
    obs.delete(); done_a = 0; done_b = 0;
    for (int i = 0; i < NR; i++) begin
      la.push_back({1'($urandom), 4'h0, 4'($urandom_range(15)), 1'b0, 7'($urandom)});
      lb.push_back({1'($urandom), 4'h0, 4'($urandom_range(15)), 1'b1, 7'($urandom)});
    end
    fork
      begin
        while (!(done_a && done_b)) begin tick_i = 1'($urandom); step(); end
      end
      begin
        bit ok;
        for (int i = 0; i < NR; i++) begin
          send(0, la[i][16], la[i][11:8], la[i][7:0], 400, ok);
          if (ok) acks_a++;
          repeat ($urandom_range(2)) step();
        end
        done_a = 1;
      end
      begin
        bit ok;
        for (int i = 0; i < NR; i++) begin
          send(1, lb[i][16], lb[i][11:8], lb[i][7:0], 400, ok);
          if (ok) acks_b++;
          repeat ($urandom_range(2)) step();
        end
        done_b = 1;
      end
    join
    n_checks++; if (acks_a != NR) $display("FAIL rand_acks_a: got %0d exp %0d", acks_a, NR); else n_pass++;
    n_checks++; if (acks_b != NR) $display("FAIL rand_acks_b: got %0d exp %0d", acks_b, NR); else n_pass++;
    drain(400);
    n_checks++; if (obs.size() != 2*NR) $display("FAIL rand_trace_len: got %0d exp %0d", obs.size(), 2*NR); else n_pass++;
    foreach (obs[i]) begin
      if (obs[i][7] == 1'b0) begin
        n_checks++; if (ia >= NR || obs[i] !== la[ia]) $display("FAIL rand_a[%0d]: got %h exp %h", ia, obs[i], (ia < NR) ? la[ia] : 17'h0); else n_pass++;
        ia++;
      end else begin
        n_checks++; if (ib >= NR || obs[i] !== lb[ib]) $display("FAIL rand_b[%0d]: got %h exp %h", ib, obs[i], (ib < NR) ? lb[ib] : 17'h0); else n_pass++;
        ib++;
      end
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    obs.delete(); tick_i = 1'b0;
    for (int i = 0; i < 4; i++) send(0, 1'b0, 4'(i + 1), 8'(8'hC0 + i), 6, ok);
    cyc(1);
    n_checks++; if ({psg_bdir_o, psg_bc_o, fifo_count_o} !== {2'b11, 3'd3}) $display("FAIL arst_pre: got %b/%0d exp 11/3", {psg_bdir_o, psg_bc_o}, fifo_count_o); else n_pass++;
    tick_i = 1'b0;
    #2 system_reset_n = 1'b0;
    #1;
    n_checks++; if ({psg_bdir_o, psg_bc_o, psg_reset_n_o} !== 3'b000) $display("FAIL arst_bus: got %b exp 000", {psg_bdir_o, psg_bc_o, psg_reset_n_o}); else n_pass++;
    n_checks++; if (fifo_count_o !== 0) $display("FAIL arst_flush: got %0d exp 0", fifo_count_o); else n_pass++;
    n_checks++; if (psg_data_o !== 8'h00) $display("FAIL arst_data: got %h exp 00", psg_data_o); else n_pass++;
    #3 system_reset_n = 1'b1;
    step();
    n_checks++; if (psg_reset_n_o !== 1'b0) $display("FAIL arst_rst_seq: got %b exp 0", psg_reset_n_o); else n_pass++;
    for (int i = 0; i < 40; i++) cyc(1);
    n_checks++; if ({psg_reset_n_o, busy_o} !== 2'b10) $display("FAIL arst_after: reset_n/busy got %b exp 10", {psg_reset_n_o, busy_o}); else n_pass++;
    n_checks++; if (obs.size() != 0) $display("FAIL arst_no_writes: got %0d exp 0", obs.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_collision();
    test_full();
    test_psg_reset();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/psg_write_sequencer.md
Name: psg_write_sequencer

Overview:
- Sequences AY-3-8913/YM2149 register writes for the two-PSG Mockingboard datapath.
- Accepts (chip, register, value) write requests from two requesters (A: VIA/host path, B: internal init/config engine) and arbitrates them round-robin into a small FIFO.
- Drains the FIFO by generating the PSG bus protocol: latch-address, inactive, write-data, inactive.
- Owns the PSG reset line, asserting it at power-up and on request.

Parameters:
PHASE_TICKS, 1, number of tick_i strobes each bus phase is held (>=1)
FIFO_DEPTH, 4, write-request FIFO entries (power of two, >=2)

Ports:
clk_logic  in  1  system logic clock
system_reset_n  in  1  asynchronous active-low reset
tick_i  in  1  one-cycle bus-phase strobe (PSG CE rate, phi1_negedge)
a_req_i  in  1  requester A write request, held until ack
a_chip_i  in  1  requester A target PSG (0 left, 1 right)
a_reg_i  in  4  requester A PSG register address
a_data_i  in  8  requester A register value
a_ack_o  out  1  one-cycle pulse: A's request accepted into FIFO
b_req_i, b_chip_i, b_reg_i, b_data_i, b_ack_o  same as A, for requester B
reset_psg_i  in  1  one-cycle pulse requesting a PSG reset sequence
psg_sel_o  out  1  PSG addressed by current cycle (0 left, 1 right)
psg_bdir_o  out  1  PSG BDIR
psg_bc_o  out  1  PSG BC1
psg_reset_n_o  out  1  PSG reset, active low, drives both chips
psg_data_o  out  8  PSG data bus
busy_o  out  1  FSM not in IDLE, or FIFO non-empty
fifo_count_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Clock and reset: one clock, clk_logic. system_reset_n is asynchronous, active-low. All state is reset asynchronously.
- Reset values:
  - psg_bdir_o=0, psg_bc_o=0, psg_data_o=0, psg_sel_o=0
  - psg_reset_n_o=0, acks=0, FIFO empty, round-robin pointer = A
  - FSM in RST with its phase counter loaded
- Arbitration and enqueue:
  - Evaluated every cycle. A request is eligible if req=1, the FIFO is not full, and that requester was not acked the previous cycle. The last rule prevents a double enqueue of a held request.
  - Only one requester is eligible: it wins.
  - Both eligible: the round-robin pointer wins, then the pointer flips to the other requester.
  - Winner: ack pulses high for exactly 1 cycle; {chip, reg, data} is written to the FIFO the same cycle.
  - FIFO full: no ack, requests wait, no data is lost.
  - An enqueue and a dequeue in the same cycle are allowed; count is unchanged.
- Phase timing: every state except IDLE lasts PHASE_TICKS tick_i strobes. The counter loads on state entry and decrements on tick_i. The state advances on the tick_i where the counter is 0.
- FSM states and outputs:
  - RST: reset_n=0, bdir=0, bc=0. Lasts 2*PHASE_TICKS ticks, then IDLE.
  - IDLE: bdir=0, bc=0, reset_n=1.
    - If a reset is pending, go to RST and clear pending.
    - Else if the FIFO is non-empty, pop the head into the holding register and go to LATCH. The pop happens in the IDLE cycle; LATCH starts the next cycle.
  - LATCH: bdir=1, bc=1, data={4'b0,reg}, sel=chip.
  - GAP1: bdir=0, bc=0, data held.
  - WRITE: bdir=1, bc=0, data=value.
  - GAP2: bdir=0, bc=0. Then IDLE.
- Reset requests:
  - reset_psg_i sets a sticky pending flag. It is serviced only from IDLE and has priority over the FIFO.
  - A write in flight always completes first.
  - FIFO contents survive a PSG reset.
  - A reset_psg_i arriving while in RST sets pending again, so one more RST follows.
- Register values: register addresses 14–15 are passed through unmodified; no range checking.
- tick_i low: FSM and counters freeze; enqueue still operates.
- Wrap-around: FIFO pointers wrap modulo FIFO_DEPTH. fifo_count_o ranges 0..FIFO_DEPTH.
- Asynchronous reset mid-cycle: outputs go immediately to reset values. The FIFO is flushed and the power-up RST sequence reruns.

Test Plan:
- Reset release, PHASE_TICKS=1, tick_i every 4 clk -> psg_reset_n_o stays 0 through 2 ticks, then 1; bdir/bc stay 0; busy_o=0.
- A writes chip0 reg 7 = 0x38, tick_i every cycle -> a_ack_o one pulse; then LATCH (bdir=1, bc=1, data=0x07, sel=0), GAP1, WRITE (bdir=1, bc=0, data=0x38), GAP2, 1 tick each; busy_o drops after GAP2.
- A and B assert on the same cycle, held -> A acked first, B acked the next cycle; second collision acks B first; PSG cycles issue in ack order.
- FIFO_DEPTH=4, tick_i held low, A issues 6 requests -> 4 acks, fifo_count_o=4, A stalls; one tick sequence drains one entry, 5th ack follows; no entry lost or duplicated.
- reset_psg_i during WRITE of chip1 reg 8 = 0x0F -> write completes through GAP2, then RST (reset_n=0 for 2*PHASE_TICKS ticks), then the queued entries issue.
- system_reset_n pulsed low during LATCH with 3 queued entries -> bdir/bc drop to 0 immediately, fifo_count_o=0, RST sequence reruns, no further writes.
